// File: rtl/mem_block_mover_if.sv
// rtl/mem_block_mover_if.sv - block-port bus between the block mover and the coprocessor memory
interface mem_block_mover_if #(
  parameter int log_size   = 10,
  parameter int cell_width = 32,
  parameter int width      = 128
);
  logic [log_size-1:0]   out_mem_address;
  logic [width-1:0]      out_mem_data;
  logic                  out_mem_read_en;
  logic                  out_mem_write_en;
  logic [cell_width-1:0] out_mem_status;
  logic                  out_mem_write_status_en;
  logic [width-1:0]      in_mem_data;

  // initiator side (the block mover)
  modport master (
    output out_mem_address,
    output out_mem_data,
    output out_mem_read_en,
    output out_mem_write_en,
    output out_mem_status,
    output out_mem_write_status_en,
    input  in_mem_data
  );

  // memory side
  modport slave (
    input  out_mem_address,
    input  out_mem_data,
    input  out_mem_read_en,
    input  out_mem_write_en,
    input  out_mem_status,
    input  out_mem_write_status_en,
    output in_mem_data
  );
endinterface

// File: rtl/mem_block_mover.sv
// rtl/mem_block_mover.sv - copies consecutive multi-cell blocks inside the coprocessor memory
module mem_block_mover #(
  parameter int log_size   = 10,
  parameter int blocks     = 4,
  parameter int cell_width = 32,
  parameter int width      = blocks * cell_width
) (
  input  logic                in_clk,
  input  logic                in_reset,
  input  logic                in_start,
  input  logic [log_size-1:0] in_src_addr,
  input  logic [log_size-1:0] in_dst_addr,
  input  logic [7:0]          in_count,
  mem_block_mover_if.master   mem,
  output logic                out_busy,
  output logic                out_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_STATUS,
    S_DONE
  } state_t;

  // Pointers carry one extra bit so a step past the top of memory shows up
  // as an out-of-range address in CHECK instead of silently wrapping.
  localparam logic [log_size:0] max_base = (log_size + 1)'((1 << log_size) - blocks);
  localparam logic [log_size:0] step     = (log_size + 1)'(blocks);
  localparam logic [log_size:0] min_dst  = (log_size + 1)'(2);

  state_t                state;
  state_t                state_next;
  logic [log_size:0]     src_ptr;
  logic [log_size:0]     dst_ptr;
  logic [7:0]            remaining;
  logic [7:0]            xfer;
  logic                  err_cfg;
  logic                  err_range;
  logic [width-1:0]      buffer;

  logic                  chk_cfg;
  logic                  chk_empty;
  logic                  chk_range;
  logic [cell_width-1:0] status_word;

  logic [log_size-1:0]   address;
  logic                  read_en;
  logic                  write_en;
  logic                  status_en;
  logic [cell_width-1:0] status;

  // cells 0 and 1 hold config/status and must never be a block destination
  assign chk_cfg   = dst_ptr < min_dst;
  assign chk_empty = remaining == 8'd0;
  assign chk_range = (src_ptr > max_base) || (dst_ptr > max_base);

  // completion/error word: valid flag, two error flags, blocks transferred
  always_comb begin
    status_word       = '0;
    status_word[0]    = 1'b1;
    status_word[1]    = err_cfg;
    status_word[2]    = err_range;
    status_word[15:8] = xfer;
  end

  // state register
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state decode and per-state bus outputs
  always_comb begin
    state_next = state;
    address    = '0;
    read_en    = 1'b0;
    write_en   = 1'b0;
    status_en  = 1'b0;
    status     = '0;
    out_busy   = 1'b1;
    out_done   = 1'b0;
    case (state)
      S_IDLE: begin
        out_busy = 1'b0;
        if (in_start) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (chk_cfg || chk_empty || chk_range) begin
          state_next = S_STATUS;
        end else begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        address    = src_ptr[log_size-1:0];
        read_en    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        address    = dst_ptr[log_size-1:0];
        write_en   = 1'b1;
        state_next = S_CHECK;
      end
      S_STATUS: begin
        status_en  = 1'b1;
        status     = status_word;
        state_next = S_DONE;
      end
      S_DONE: begin
        out_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // transfer bookkeeping: latch request, record errors, capture read data, advance
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      xfer      <= '0;
      err_cfg   <= 1'b0;
      err_range <= 1'b0;
      buffer    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_start) begin
            src_ptr   <= {1'b0, in_src_addr};
            dst_ptr   <= {1'b0, in_dst_addr};
            remaining <= in_count;
            xfer      <= '0;
            err_cfg   <= 1'b0;
            err_range <= 1'b0;
          end
        end
        S_CHECK: begin
          if (chk_cfg) begin
            err_cfg <= 1'b1;
          end else if (!chk_empty && chk_range) begin
            err_range <= 1'b1;
          end
        end
        S_WAIT: begin
          // the memory only drives valid data in the cycle after READ
          buffer <= mem.in_mem_data;
        end
        S_WRITE: begin
          src_ptr   <= src_ptr + step;
          dst_ptr   <= dst_ptr + step;
          remaining <= remaining - 8'd1;
          xfer      <= xfer + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem.out_mem_address         = address;
  assign mem.out_mem_data            = buffer;
  assign mem.out_mem_read_en         = read_en;
  assign mem.out_mem_write_en        = write_en;
  assign mem.out_mem_status          = status;
  assign mem.out_mem_write_status_en = status_en;

endmodule

// File: tb/tb_mem_block_mover.sv
// tb/tb_mem_block_mover.sv - directed bench for mem_block_mover with a block-port memory model
module tb_mem_block_mover;

  localparam int log_size   = 10;
  localparam int blocks     = 4;
  localparam int cell_width = 32;
  localparam int width      = blocks * cell_width;
  localparam int mem_cells  = 1 << log_size;

  logic                in_clk = 1'b0;
  logic                in_reset;
  logic                in_start;
  logic [log_size-1:0] in_src_addr;
  logic [log_size-1:0] in_dst_addr;
  logic [7:0]          in_count;
  logic                out_busy;
  logic                out_done;

  mem_block_mover_if #(.log_size(log_size), .cell_width(cell_width), .width(width)) mbus ();

  mem_block_mover #(
    .log_size(log_size), .blocks(blocks), .cell_width(cell_width), .width(width)
  ) dut (
    .in_clk      (in_clk),
    .in_reset    (in_reset),
    .in_start    (in_start),
    .in_src_addr (in_src_addr),
    .in_dst_addr (in_dst_addr),
    .in_count    (in_count),
    .mem         (mbus.master),
    .out_busy    (out_busy),
    .out_done    (out_done)
  );

  always #5 in_clk = ~in_clk;

  // memory preload pattern: cells 16..23 = 0x11..0x18, all others tagged with their address
  function automatic logic [31:0] init_val(input int i);
    if (i >= 16 && i <= 23) return 32'h11 + 32'(i - 16);
    return 32'hA000_0000 | 32'(i);
  endfunction

  logic [31:0]      cells [0:mem_cells-1];
  logic             init_mem;
  logic             rd_valid;
  logic [width-1:0] rd_data;

  // memory model: registered block read, block write, status write to cell 1
  always @(posedge in_clk) begin
    if (init_mem) begin
      for (int i = 0; i < mem_cells; i++) cells[i] <= init_val(i);
    end else begin
      if (mbus.out_mem_write_en)
        for (int i = 0; i < blocks; i++)
          cells[(int'(mbus.out_mem_address) + i) % mem_cells] <= mbus.out_mem_data[i*32 +: 32];
      if (mbus.out_mem_write_status_en) cells[1] <= mbus.out_mem_status;
    end
    rd_valid <= mbus.out_mem_read_en;
    if (mbus.out_mem_read_en)
      for (int i = 0; i < blocks; i++)
        rd_data[i*32 +: 32] <= cells[(int'(mbus.out_mem_address) + i) % mem_cells];
  end

  assign mbus.in_mem_data = rd_valid ? rd_data : '0;

  int n_cmp = 0;
  int n_mis = 0;
  int multi_en = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int src, input int dst, input int cnt);
    @(negedge in_clk);
    in_start    = 1'b1;
    in_src_addr = log_size'(src);
    in_dst_addr = log_size'(dst);
    in_count    = 8'(cnt);
    @(posedge in_clk);
    #1 in_start = 1'b0;
  endtask

  // starts a transfer and watches it cycle by cycle (cycle 1 = the cycle after the start edge)
  task automatic run(input int src, input int dst, input int cnt, input int pulse_cyc,
                     output int done_cyc, output int done_cnt,
                     output int rd_cnt, output int wr_cnt, output int st_cnt,
                     output logic [255:0] busy_map);
    done_cyc = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0; st_cnt = 0; busy_map = '0;
    do_start(src, dst, cnt);
    for (int c = 1; c <= 200; c++) begin
      @(negedge in_clk);
      if (c == pulse_cyc) begin
        in_start    = 1'b1;
        in_src_addr = 10'd16;
        in_dst_addr = 10'd600;
        in_count    = 8'd5;
      end else begin
        in_start = 1'b0;
      end
      busy_map[c] = out_busy;
      if (mbus.out_mem_read_en) rd_cnt++;
      if (mbus.out_mem_write_en) wr_cnt++;
      if (mbus.out_mem_write_status_en) st_cnt++;
      if (int'(mbus.out_mem_read_en) + int'(mbus.out_mem_write_en) +
          int'(mbus.out_mem_write_status_en) > 1) multi_en++;
      if (out_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (done_cyc != 0 && c >= done_cyc + 3) break;
    end
  endtask

  int           dc, dn, rc, wc, sc;
  logic [255:0] bm;

  initial begin
    in_reset = 1'b1; in_start = 1'b0; init_mem = 1'b1;
    in_src_addr = '0; in_dst_addr = '0; in_count = '0;
    repeat (2) @(negedge in_clk);
    check("reset_busy", 128'(out_busy), 128'd0);
    check("reset_done", 128'(out_done), 128'd0);
    check("reset_bus", {mbus.out_mem_address, mbus.out_mem_read_en, mbus.out_mem_write_en,
                        mbus.out_mem_write_status_en, mbus.out_mem_status}, 128'd0);
    check("reset_data", 128'(mbus.out_mem_data), 128'd0);
    init_mem = 1'b0;
    in_reset = 1'b0;
    @(negedge in_clk);

    // two-block copy 16 -> 64
    run(16, 64, 2, 0, dc, dn, rc, wc, sc, bm);
    check("t1_done_cyc", 128'(dc), 128'd11);
    check("t1_done_cnt", 128'(dn), 128'd1);
    check("t1_busy_c1", 128'(bm[1]), 128'd1);
    check("t1_busy_c10", 128'(bm[10]), 128'd1);
    check("t1_busy_c12", 128'(bm[12]), 128'd0);
    check("t1_cell64", 128'(cells[64]), 128'h11);
    check("t1_cell67", 128'(cells[67]), 128'h14);
    check("t1_cell71", 128'(cells[71]), 128'h18);
    check("t1_cell72", 128'(cells[72]), 128'(init_val(72)));
    check("t1_status", 128'(cells[1]), 128'h0000_0201);

    // zero blocks
    run(16, 8, 0, 0, dc, dn, rc, wc, sc, bm);
    check("t2_done_cyc", 128'(dc), 128'd3);
    check("t2_rd_wr", 128'(rc + wc), 128'd0);
    check("t2_status_en", 128'(sc), 128'd1);
    check("t2_status", 128'(cells[1]), 128'h0000_0001);
    check("t2_cell8", 128'(cells[8]), 128'(init_val(8)));

    // destination on config/status cells
    run(16, 1, 3, 0, dc, dn, rc, wc, sc, bm);
    check("t3_done_cyc", 128'(dc), 128'd3);
    check("t3_writes", 128'(wc), 128'd0);
    check("t3_status", 128'(cells[1]), 128'h0000_0003);
    check("t3_cell0", 128'(cells[0]), 128'hA000_0000);

    // source runs off the top of memory on the third block
    run(1016, 100, 3, 0, dc, dn, rc, wc, sc, bm);
    check("t4_done_cyc", 128'(dc), 128'd11);
    check("t4_writes", 128'(wc), 128'd2);
    check("t4_cell100", 128'(cells[100]), 128'(init_val(1016)));
    check("t4_cell107", 128'(cells[107]), 128'(init_val(1023)));
    check("t4_cell108", 128'(cells[108]), 128'(init_val(108)));
    check("t4_status", 128'(cells[1]), 128'h0000_0205);

    // reset during WAIT of block 2 of a 4-block copy
    do_start(200, 300, 4);
    repeat (7) @(negedge in_clk);
    check("t5_pre_busy", 128'(out_busy), 128'd1);
    check("t5_pre_data", 128'(mbus.out_mem_data),
          {init_val(203), init_val(202), init_val(201), init_val(200)});
    in_reset = 1'b1;
    #1;
    check("t5_rst_busy", 128'(out_busy), 128'd0);
    check("t5_rst_bus", {mbus.out_mem_address, mbus.out_mem_read_en, mbus.out_mem_write_en,
                         mbus.out_mem_write_status_en, mbus.out_mem_status, out_done}, 128'd0);
    check("t5_rst_data", 128'(mbus.out_mem_data), 128'd0);
    @(negedge in_clk);
    in_reset = 1'b0;
    check("t5_cell300", 128'(cells[300]), 128'(init_val(200)));
    check("t5_cell303", 128'(cells[303]), 128'(init_val(203)));
    check("t5_cell304", 128'(cells[304]), 128'(init_val(304)));
    check("t5_cell307", 128'(cells[307]), 128'(init_val(307)));
    run(16, 400, 1, 0, dc, dn, rc, wc, sc, bm);
    check("t5_done_cyc", 128'(dc), 128'd7);
    check("t5_cell400", 128'(cells[400]), 128'h11);
    check("t5_cell403", 128'(cells[403]), 128'h14);
    check("t5_status", 128'(cells[1]), 128'h0000_0101);

    // start pulse while busy is ignored
    run(20, 500, 2, 3, dc, dn, rc, wc, sc, bm);
    check("t6_done_cyc", 128'(dc), 128'd11);
    check("t6_done_cnt", 128'(dn), 128'd1);
    check("t6_cell500", 128'(cells[500]), 128'h15);
    check("t6_cell507", 128'(cells[507]), 128'(init_val(27)));
    check("t6_cell600", 128'(cells[600]), 128'(init_val(600)));
    check("t6_status", 128'(cells[1]), 128'h0000_0201);
    repeat (3) @(negedge in_clk);
    check("t6_idle_after", 128'(out_busy), 128'd0);

    check("one_enable_max", 128'(multi_en), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
